// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: sized loads/stores on a req/ack data port,
// upstream stall while the access is outstanding, registered write-back bundle.
module mem_wb_stage #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_flush,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [1:0]  MemWrite,
    input  logic [1:0]  MemRead,
    input  logic        load_unsigned,
    input  logic [31:0] Aluout,
    input  logic [31:0] busB,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] Aluout_out,
    output logic [31:0] Memdata_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_out,
    output logic        misalign_out,
    output logic        buserr_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            berr_q, berr_d;
    logic            drop_q, drop_d;
    logic [31:0]     rdata_q, rdata_d;

    logic        is_store;
    logic        is_load;
    logic        access;
    logic [1:0]  sz;
    logic        misalign;
    logic        go;
    logic        req;
    logic [3:0]  lane_be;
    logic [31:0] wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // A store takes precedence when both request fields are set.
    assign is_store = |MemWrite;
    assign is_load  = |MemRead & ~is_store;
    assign access   = is_store | (|MemRead);
    assign sz       = is_store ? MemWrite : MemRead;
    assign misalign = access &
                      (((sz == 2'b10) & Aluout[0]) |
                       ((sz == 2'b11) & (|Aluout[1:0])));
    assign go       = access & ~misalign & ~mem_flush;

    always_comb begin
        lane_be = 4'b0000;
        wdata   = busB;
        unique case (1'b1)
            sz == 2'b01: begin
                lane_be = 4'b0001 << Aluout[1:0];
                wdata   = {4{busB[7:0]}};
            end
            sz == 2'b10: begin
                lane_be = Aluout[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{busB[15:0]}};
            end
            sz == 2'b11: begin
                lane_be = 4'b1111;
                wdata   = busB;
            end
            default: begin
                lane_be = 4'b0000;
                wdata   = busB;
            end
        endcase
    end

    assign ld_byte = 8'(rdata_q >> {Aluout[1:0], 3'b000});
    assign ld_half = 16'(rdata_q >> {Aluout[1], 4'b0000});

    always_comb begin
        ld_data = rdata_q;
        unique case (1'b1)
            MemRead == 2'b01:
                ld_data = {{24{~load_unsigned & ld_byte[7]}}, ld_byte};
            MemRead == 2'b10:
                ld_data = {{16{~load_unsigned & ld_half[15]}}, ld_half};
            default:
                ld_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        berr_d  = berr_q;
        drop_d  = drop_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    req    = 1'b1;
                    berr_d = 1'b0;
                    drop_d = 1'b0;
                    cnt_d  = '0;
                    if (dm_ack) begin
                        rdata_d = dm_rdata;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (mem_flush) drop_d = 1'b1;
                if (dm_ack) begin
                    rdata_d = dm_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == TO_W'(ACK_TIMEOUT)) begin
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
        end
    end

    // Gated by reset so an abandoned request drops the same instant.
    assign dm_req    = req & reset;
    assign mem_stall = req & reset;
    assign dm_we     = is_store;
    assign dm_be     = dm_req ? lane_be : 4'b0000;
    assign dm_addr   = {Aluout[31:2], 2'b00};
    assign dm_wdata  = wdata;

    logic        rw_d, mtr_d, mis_d, be_d;
    logic [31:0] alu_d, md_d, pc_d;
    logic [4:0]  rd_d;

    always_comb begin
        rw_d  = 1'b0;
        mtr_d = 1'b0;
        mis_d = 1'b0;
        be_d  = 1'b0;
        alu_d = '0;
        md_d  = '0;
        pc_d  = '0;
        rd_d  = '0;
        if (mem_stall | mem_flush) begin
            rw_d = 1'b0;
        end else if (state_q == S_DONE) begin
            if (!drop_q) begin
                rw_d  = RegWrite & ~berr_q;
                mtr_d = MemtoReg;
                alu_d = Aluout;
                md_d  = (is_load & ~berr_q) ? ld_data : 32'h0;
                pc_d  = pc;
                rd_d  = rd;
                be_d  = berr_q;
            end
        end else begin
            rw_d  = RegWrite & ~misalign;
            mtr_d = MemtoReg;
            alu_d = Aluout;
            pc_d  = pc;
            rd_d  = rd;
            mis_d = misalign;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            Aluout_out   <= '0;
            Memdata_out  <= '0;
            pc_out       <= '0;
            rd_out       <= '0;
            misalign_out <= 1'b0;
            buserr_out   <= 1'b0;
        end else begin
            RegWrite_out <= rw_d;
            MemtoReg_out <= mtr_d;
            Aluout_out   <= alu_d;
            Memdata_out  <= md_d;
            pc_out       <= pc_d;
            rd_out       <= rd_d;
            misalign_out <= mis_d;
            buserr_out   <= be_d;
        end
    end

endmodule
